clk_div_gen: RTL and testbench

- Single-clock fractional clock divider and strobe generator; the inverse of the DCM multiplier path.
- Takes the fast system clock produced by a DCM and derives a low-rate tick strobe plus a 50%-average square wave from it.
- Typical use: recover a 1 MHz timebase from 27 MHz or 25 MHz. Also yields divided enables for the CPU, timer and LCD blocks without extra DCMs.
- Gates itself on the DCM `ready` and only reports `ready` once the derived timebase has settled.

---
 rtl/clk_div_gen_if.sv | 20 ++
 rtl/clk_div_gen.sv | 116 +++++++++++
 tb/tb_clk_div_gen.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_gen_if.sv
// Control and status bundle for clk_div_gen: the master side drives the DCM ready and
// run enable, and the divider (slave side) returns the derived timebase.
interface clk_div_gen_if;
    logic       src_ready;
    logic       en;
    logic       tick;
    logic       clk_div;
    logic       ready;
    logic [7:0] tick_cnt;

    modport master (
        output src_ready, en,
        input  tick, clk_div, ready, tick_cnt
    );

    modport slave (
        input  src_ready, en,
        output tick, clk_div, ready, tick_cnt
    );
endinterface

// File: rtl/clk_div_gen.sv
// Fractional clock divider: phase accumulators derive a tick strobe and a square wave at
// OUT_FREQ_KHZ from clk, gated on a synchronised source-ready and a settle period.
module clk_div_gen #(
    parameter int unsigned IN_FREQ_KHZ  = 27000,
    parameter int unsigned OUT_FREQ_KHZ = 1000,
    parameter int unsigned SETTLE_TICKS = 4,
    parameter int unsigned ACC_W        = 32
) (
    input logic          clk,
    input logic          rst_b,
    clk_div_gen_if.slave bus
);

    localparam longint unsigned AccNeed = longint'(IN_FREQ_KHZ) + 2 * longint'(OUT_FREQ_KHZ);

    if (2 * OUT_FREQ_KHZ > IN_FREQ_KHZ) begin : g_bad_ratio
        $error("clk_div_gen: 2*OUT_FREQ_KHZ must not exceed IN_FREQ_KHZ");
    end
    if (SETTLE_TICKS < 1 || SETTLE_TICKS > 255) begin : g_bad_settle
        $error("clk_div_gen: SETTLE_TICKS must be in 1..255");
    end
    if (ACC_W < 64 && AccNeed >= (64'd1 << ACC_W)) begin : g_bad_width
        $error("clk_div_gen: ACC_W too narrow for IN_FREQ_KHZ + 2*OUT_FREQ_KHZ");
    end

    localparam logic [ACC_W-1:0] StepTick = ACC_W'(OUT_FREQ_KHZ);
    localparam logic [ACC_W-1:0] StepHalf = ACC_W'(2 * OUT_FREQ_KHZ);
    localparam logic [ACC_W-1:0] Modulus  = ACC_W'(IN_FREQ_KHZ);

    typedef enum logic [1:0] {StIdle, StSettle, StLocked} state_e;

    state_e           state_q, state_d;
    logic             sync_q, run_ok_q;
    logic [ACC_W-1:0] tick_acc_q, tick_acc_d;
    logic [ACC_W-1:0] half_acc_q, half_acc_d;
    logic [ACC_W-1:0] tick_sum, half_sum;
    logic             tick_wrap, half_wrap;
    logic [7:0]       settle_q, settle_d;
    logic [7:0]       tick_cnt_q, tick_cnt_d;
    logic             tick_q, tick_d;
    logic             div_q, div_d;

    always_comb begin
        tick_sum   = tick_acc_q + StepTick;
        half_sum   = half_acc_q + StepHalf;
        tick_wrap  = (tick_sum >= Modulus);
        half_wrap  = (half_sum >= Modulus);

        state_d    = state_q;
        tick_acc_d = tick_acc_q;
        half_acc_d = half_acc_q;
        settle_d   = settle_q;
        tick_cnt_d = tick_cnt_q;
        tick_d     = 1'b0;
        div_d      = div_q;

        // Losing the source restarts the timebase from phase 0; tick_cnt survives.
        if (!run_ok_q) begin
            state_d    = StIdle;
            tick_acc_d = '0;
            half_acc_d = '0;
            settle_d   = '0;
            div_d      = 1'b0;
        end else if (bus.en) begin
            if (state_q == StIdle) begin
                state_d = StSettle;
            end else begin
                tick_acc_d = tick_wrap ? (tick_sum - Modulus) : tick_sum;
                half_acc_d = half_wrap ? (half_sum - Modulus) : half_sum;
                if (half_wrap) begin
                    div_d = ~div_q;
                end
                if (tick_wrap) begin
                    tick_d     = 1'b1;
                    tick_cnt_d = tick_cnt_q + 8'd1;
                    if (state_q == StSettle) begin
                        settle_d = settle_q + 8'd1;
                        if (settle_q + 8'd1 == 8'(SETTLE_TICKS)) begin
                            state_d = StLocked;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sync_q     <= 1'b0;
            run_ok_q   <= 1'b0;
            state_q    <= StIdle;
            tick_acc_q <= '0;
            half_acc_q <= '0;
            settle_q   <= '0;
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
            div_q      <= 1'b0;
        end else begin
            sync_q     <= bus.src_ready;
            run_ok_q   <= sync_q;
            state_q    <= state_d;
            tick_acc_q <= tick_acc_d;
            half_acc_q <= half_acc_d;
            settle_q   <= settle_d;
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
            div_q      <= div_d;
        end
    end

    assign bus.tick     = tick_q;
    assign bus.clk_div  = div_q;
    assign bus.ready    = (state_q == StLocked);
    assign bus.tick_cnt = tick_cnt_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: three dividers (27, 24 and 25 MHz inputs) run in lockstep against
// a model that predicts ticks and clk_div from the running-edge count alone.
module tb_clk_div_gen;

    localparam int unsigned OUT_K  = 1000;
    localparam int unsigned SETTLE = 4;

    int unsigned in_k [3] = '{27000, 24000, 25000};

    logic clk = 1'b0;
    logic rst_b;
    logic src_ready;
    logic en;

    always #5 clk = ~clk;

    clk_div_gen_if if0 ();
    clk_div_gen_if if1 ();
    clk_div_gen_if if2 ();

    assign if0.src_ready = src_ready;
    assign if1.src_ready = src_ready;
    assign if2.src_ready = src_ready;
    assign if0.en        = en;
    assign if1.en        = en;
    assign if2.en        = en;

    clk_div_gen #(.IN_FREQ_KHZ(27000), .OUT_FREQ_KHZ(1000), .SETTLE_TICKS(4), .ACC_W(32)) u_dut0 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (if0)
    );
    clk_div_gen #(.IN_FREQ_KHZ(24000), .OUT_FREQ_KHZ(1000), .SETTLE_TICKS(4), .ACC_W(32)) u_dut1 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (if1)
    );
    clk_div_gen #(.IN_FREQ_KHZ(25000), .OUT_FREQ_KHZ(1000), .SETTLE_TICKS(4), .ACC_W(32)) u_dut2 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (if2)
    );

    logic [2:0] d_tick, d_div, d_rdy;
    logic [7:0] d_cnt [3];
    assign d_tick   = {if2.tick, if1.tick, if0.tick};
    assign d_div    = {if2.clk_div, if1.clk_div, if0.clk_div};
    assign d_rdy    = {if2.ready, if1.ready, if0.ready};
    assign d_cnt[0] = if0.tick_cnt;
    assign d_cnt[1] = if1.tick_cnt;
    assign d_cnt[2] = if2.tick_cnt;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Model: p1/p2 hold src_ready as seen one and two edges ago; n counts running edges.
    bit       p1, p2, active;
    longint   n;
    bit       exp_tick [3];
    bit       exp_div  [3];
    bit       exp_rdy  [3];
    bit [7:0] tcnt     [3];

    function automatic longint nt(longint k, int i);
        return (k * longint'(OUT_K)) / longint'(in_k[i]);
    endfunction

    function automatic longint nh(longint k, int i);
        return (2 * k * longint'(OUT_K)) / longint'(in_k[i]);
    endfunction

    task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s[%0d]: observed %0d expected %0d", tag, idx, obs, expv);
        end
    endtask

    task automatic model_reset();
        p1 = 0;
        p2 = 0;
        active = 0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            exp_tick[i] = 0;
            exp_div[i]  = 0;
            exp_rdy[i]  = 0;
            tcnt[i]     = '0;
        end
    endtask

    task automatic model_edge();
        bit ok, ran;
        ok  = p2;
        p2  = p1;
        p1  = src_ready;
        ran = 0;
        if (!ok) begin
            active = 0;
            n = 0;
        end else if (en) begin
            if (!active) active = 1;
            else begin
                n++;
                ran = 1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            exp_tick[i] = ran && (nt(n, i) != nt(n - 1, i));
            if (exp_tick[i]) tcnt[i] = tcnt[i] + 8'd1;
            exp_div[i] = (nh(n, i) % 2) == 1;
            exp_rdy[i] = active && (nt(n, i) >= longint'(SETTLE));
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk("tick", i, 32'(d_tick[i]), 32'(exp_tick[i]));
            chk("clk_div", i, 32'(d_div[i]), 32'(exp_div[i]));
            chk("ready", i, 32'(d_rdy[i]), 32'(exp_rdy[i]));
            chk("tick_cnt", i, 32'(d_cnt[i]), 32'(tcnt[i]));
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk(tag, i, {21'd0, d_tick[i], d_div[i], d_rdy[i], d_cnt[i]}, 32'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int  first_tick, t25, g25, seen0, bound, drop_cnt;
        bit  prev_div1, prev_div2, prev_rdy0, win_done;

        rst_b = 1'b1;
        src_ready = 1'b0;
        en = 1'b0;
        #1 rst_b = 1'b0;
        #2 check_zero("reset_state");
        #10;
        model_reset();
        rst_b = 1'b0;
        rst_b = 1'b1;
        src_ready = 1'b1;
        en = 1'b1;

        // Bring-up from reset with en held high.
        first_tick = 0; t25 = 0; g25 = 0; seen0 = 0;
        prev_div1 = 0; prev_div2 = 0; prev_rdy0 = 0; win_done = 0;
        for (int k = 1; k <= 1010; k++) begin
            step();
            if (first_tick == 0 && d_tick[0]) first_tick = k;
            if (d_tick[0]) begin
                seen0++;
                if (seen0 == 10) chk("tick_cnt_after_10", 0, 32'(d_cnt[0]), 32'd10);
            end
            if (d_rdy[0] && !prev_rdy0) chk("ready_with_4th_tick", 0, 32'(seen0), 32'd4);
            prev_rdy0 = d_rdy[0];
            if (d_tick[1]) chk("tick_on_toggle", 1, 32'(d_div[1] != prev_div1), 32'd1);
            prev_div1 = d_div[1];
            if (!win_done) begin
                if (d_tick[2]) t25++;
                if (d_div[2] != prev_div2) g25++;
                if (n == 1000) begin
                    chk("ticks_in_1000", 2, 32'(t25), 32'd40);
                    chk("toggles_in_1000", 2, 32'(g25), 32'd80);
                    win_done = 1;
                end
            end
            prev_div2 = d_div[2];
        end
        chk("first_tick_cycle", 0, 32'(first_tick), 32'd30);

        // Drop src_ready for 5 cycles while locked with clk_div high.
        bound = 0;
        while (!(exp_div[0] && exp_rdy[0]) && bound < 100) begin
            step();
            bound++;
        end
        chk("drop_precond", 0, 32'(d_div[0] & d_rdy[0]), 32'd1);
        src_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 3) begin
                chk("drop_ready", 0, 32'(d_rdy[0]), 32'd0);
                chk("drop_clk_div", 0, 32'(d_div[0]), 32'd0);
                chk("drop_tick", 0, 32'(d_tick[0]), 32'd0);
            end
        end
        src_ready = 1'b1;
        for (int k = 0; k < 200; k++) step();
        chk("relock_ready", 0, 32'(d_rdy[0]), 32'd1);

        // Pause for 10 cycles just before a tick is due.
        bound = 0;
        while (!(active && nt(n + 1, 0) != nt(n, 0)) && bound < 100) begin
            step();
            bound++;
        end
        en = 1'b0;
        for (int k = 0; k < 10; k++) step();
        en = 1'b1;
        step();
        chk("tick_after_resume", 0, 32'(d_tick[0]), 32'd1);
        for (int k = 0; k < 27; k++) step();
        chk("spacing_after_resume", 0, 32'(d_tick[0]), 32'd1);

        // Random enable gaps and source dropouts.
        drop_cnt = 0;
        for (int k = 0; k < 3000; k++) begin
            en = ($urandom_range(0, 7) != 0);
            if (drop_cnt > 0) begin
                drop_cnt--;
                src_ready = 1'b0;
            end else begin
                src_ready = 1'b1;
                if ($urandom_range(0, 199) == 0) drop_cnt = $urandom_range(1, 8);
            end
            step();
        end

        // Asynchronous reset between clock edges, then recovery.
        src_ready = 1'b1;
        en = 1'b1;
        #2 rst_b = 1'b0;
        #1 check_zero("async_reset");
        model_reset();
        #2 rst_b = 1'b1;
        first_tick = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (first_tick == 0 && d_tick[0]) first_tick = k;
        end
        chk("first_tick_after_reset", 0, 32'(first_tick), 32'd30);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
